// File: rtl/ising_pkg.sv
// -----------------------------------------------------------------------------
// ising_pkg
// Shared constants and types for the analog Ising weight-load path.
//   ANALOG_DEPTH  default number of analog rows (one-hot write address width)
//   DATA_W        default row width in bits (DATASPIN*BITJ)
//   CFG_W         width of the timing/row-count fields held in wload_cfg_t
//   wload_state_e sequencer states
//   wload_cfg_t   configuration sampled when a load sequence is accepted
// -----------------------------------------------------------------------------
package ising_pkg;

  localparam int ANALOG_DEPTH = 256;
  localparam int DATA_W       = 256;
  localparam int CFG_W        = 32;

  typedef enum logic [2:0] {
    WL_IDLE,
    WL_READ,
    WL_WAIT,
    WL_HIGH,
    WL_LOW,
    WL_DONE
  } wload_state_e;

  typedef struct packed {
    logic [CFG_W-1:0] num_rows;  // already clamped to the analog depth
    logic [CFG_W-1:0] wen_high;  // already forced to at least 1
    logic [CFG_W-1:0] wen_low;   // 0 skips the LOW phase
  } wload_cfg_t;

endpackage

// File: rtl/analog_wload_seq_if.sv
// -----------------------------------------------------------------------------
// analog_wload_seq_if
// Bundles the wmem read port and the analog macro weight-write port.
//   wmem_ren      read enable towards wmem
//   wmem_raddr    wmem row address
//   wmem_rdata    wmem row data, valid one cycle after wmem_ren
//   analog_wen    analog write enable
//   analog_waddr  one-hot analog row select
//   analog_wdata  analog write data
// Modports: master = the sequencer, slave = wmem + analog macro side.
// -----------------------------------------------------------------------------
interface analog_wload_seq_if #(
  parameter int ANALOG_DEPTH = ising_pkg::ANALOG_DEPTH,
  parameter int DATA_W       = ising_pkg::DATA_W
);

  localparam int ADDR_W = $clog2(ANALOG_DEPTH);

  logic                    wmem_ren;
  logic [ADDR_W-1:0]       wmem_raddr;
  logic [DATA_W-1:0]       wmem_rdata;
  logic                    analog_wen;
  logic [ANALOG_DEPTH-1:0] analog_waddr;
  logic [DATA_W-1:0]       analog_wdata;

  modport master (
    output wmem_ren, wmem_raddr, analog_wen, analog_waddr, analog_wdata,
    input  wmem_rdata
  );

  modport slave (
    input  wmem_ren, wmem_raddr, analog_wen, analog_waddr, analog_wdata,
    output wmem_rdata
  );

endinterface

// File: rtl/analog_wload_seq_phase_cnt.sv
// -----------------------------------------------------------------------------
// wload_phase_cnt
// Loadable down-counter with a zero flag; times both the HIGH and LOW phases.
// The count saturates at zero, so any load value up to 2^CNT_W-1 is safe.
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   load_i      load load_val_i (takes priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement when non-zero
//   zero_o      count is zero
// -----------------------------------------------------------------------------
module wload_phase_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge values of its inputs, whatever the statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/analog_wload_seq.sv
// -----------------------------------------------------------------------------
// analog_wload_seq
// Loads coupling weights row by row from wmem into the analog Ising macro.
// Per row: READ (ren) -> WAIT (capture data) -> HIGH (wen, H cycles)
// -> LOW (hold, L cycles, skipped when L=0). Row period is 2+H+L cycles.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   start_i         one-cycle start pulse, accepted only when idle
//   abort_i         synchronous abort, honoured only while busy
//   num_rows_i      rows to load (clamped to ANALOG_DEPTH), sampled at start
//   wen_high_i      write-enable high cycles (0 acts as 1), sampled at start
//   wen_low_i       post-write hold cycles (0 skips LOW), sampled at start
//   wl              wmem read port + analog write port (master modport)
//   busy_o          sequence in progress (READ/WAIT/HIGH/LOW)
//   done_o          one-cycle completion pulse
//   aborted_o       sticky: last sequence aborted; cleared by the next start
// -----------------------------------------------------------------------------
module analog_wload_seq #(
  parameter int ANALOG_DEPTH = ising_pkg::ANALOG_DEPTH,
  parameter int DATA_W       = ising_pkg::DATA_W,
  parameter int CNT_W        = ising_pkg::CFG_W,
  parameter int ADDR_W       = $clog2(ANALOG_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [ADDR_W:0]      num_rows_i,
  input  logic [CNT_W-1:0]     wen_high_i,
  input  logic [CNT_W-1:0]     wen_low_i,
  analog_wload_seq_if.master   wl,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 aborted_o
);

  import ising_pkg::*;

  localparam int              ROW_W   = ADDR_W + 1;
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

  wload_state_e            state_q;
  wload_cfg_t              cfg_q;
  logic [ROW_W-1:0]        row_q;
  logic                    ren_q;
  logic [ADDR_W-1:0]       raddr_q;
  logic                    wen_q;
  logic [ANALOG_DEPTH-1:0] waddr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    aborted_q;

  // Start-time configuration after clamping / substitution.
  logic [ROW_W-1:0] num_rows_clamped;
  logic [CNT_W-1:0] wen_high_eff;

  assign num_rows_clamped = (num_rows_i > ROW_W'(ANALOG_DEPTH)) ? ROW_W'(ANALOG_DEPTH)
                                                                 : num_rows_i;
  assign wen_high_eff     = (wen_high_i == '0) ? CNT_W'(1) : wen_high_i;

  // Row bookkeeping; the row counter is one bit wider than the address so a
  // full-depth load compares against ANALOG_DEPTH without wrapping.
  logic [ROW_W-1:0] row_next;
  logic             row_last;
  assign row_next = row_q + ROW_ONE;
  assign row_last = (CFG_W'(row_next) == cfg_q.num_rows);

  // Phase counter control: loaded with (phase length - 1) on entry to HIGH
  // and LOW, so zero_o marks the final cycle of the current phase.
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;

  // NOTE: every always_comb output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    if (state_q == WL_WAIT) begin
      cnt_load = 1'b1;
      cnt_val  = cfg_q.wen_high[CNT_W-1:0] - CNT_W'(1);
    end else if ((state_q == WL_HIGH) && cnt_zero) begin
      // Harmless when L=0: the next WAIT reloads before the count is used.
      cnt_load = 1'b1;
      cnt_val  = cfg_q.wen_low[CNT_W-1:0] - CNT_W'(1);
    end else begin
      cnt_dec  = (state_q == WL_HIGH) || (state_q == WL_LOW);
    end
  end

  wload_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Last cycle of a row: end of LOW, or end of HIGH when LOW is skipped.
  logic row_end;
  assign row_end = cnt_zero &&
                   (((state_q == WL_HIGH) && (cfg_q.wen_low == '0)) || (state_q == WL_LOW));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the row data register is a plain flop bank, so it is reset
      // along with the control state to keep the write bus at zero.
      state_q   <= WL_IDLE;
      cfg_q     <= '0;
      row_q     <= '0;
      ren_q     <= 1'b0;
      raddr_q   <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else if (busy_q && abort_i) begin
      state_q   <= WL_IDLE;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      aborted_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        WL_IDLE: begin
          if (start_i) begin
            aborted_q      <= 1'b0;
            cfg_q.num_rows <= CFG_W'(num_rows_clamped);
            cfg_q.wen_high <= CFG_W'(wen_high_eff);
            cfg_q.wen_low  <= CFG_W'(wen_low_i);
            row_q          <= '0;
            if (num_rows_clamped == '0) begin
              state_q <= WL_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= WL_READ;
              ren_q   <= 1'b1;
              raddr_q <= '0;
              busy_q  <= 1'b1;
            end
          end
        end
        WL_READ: begin
          ren_q   <= 1'b0;
          state_q <= WL_WAIT;
        end
        WL_WAIT: begin
          wdata_q <= wl.wmem_rdata;
          waddr_q <= ANALOG_DEPTH'(1) << row_q[ADDR_W-1:0];
          wen_q   <= 1'b1;
          state_q <= WL_HIGH;
        end
        WL_HIGH: begin
          if (cnt_zero) begin
            wen_q   <= 1'b0;
            state_q <= WL_LOW;
          end
        end
        WL_LOW: ;
        WL_DONE: state_q <= WL_IDLE;
        default: state_q <= WL_IDLE;
      endcase

      // Placed after the case so it overrides the HIGH->LOW move when LOW is
      // skipped; both paths share the same next-row decision.
      if (row_end) begin
        waddr_q <= '0;
        wdata_q <= '0;
        if (row_last) begin
          state_q <= WL_DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end else begin
          row_q   <= row_next;
          state_q <= WL_READ;
          ren_q   <= 1'b1;
          raddr_q <= row_next[ADDR_W-1:0];
        end
      end
    end
  end

  assign wl.wmem_ren     = ren_q;
  assign wl.wmem_raddr   = raddr_q;
  assign wl.analog_wen   = wen_q;
  assign wl.analog_waddr = waddr_q;
  assign wl.analog_wdata = wdata_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign aborted_o       = aborted_q;

endmodule
